// File: rtl/prbs_pkg.sv
// Shared definitions for the 32-bit PRBS (x^32+x^30+x^26+x^25+1) generator/checker pair.
// The feedback bit is also the serial output bit.
package prbs_pkg;

    localparam int              PRBS_W    = 32;
    localparam logic [PRBS_W-1:0] PRBS_TAPS = 32'hA300_0000;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    function automatic logic prbs_next(input logic [PRBS_W-1:0] h);
        return ^(h & PRBS_TAPS);
    endfunction

endpackage

// File: rtl/prbs32_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes effect before a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end
        if (inc_i && (q_d != '1)) begin
            q_d = q_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/prbs32_checker.sv
// Self-synchronising checker for the serial 32-bit PRBS stream: lock, error flag/count, loss of lock.
//   state  | meaning
//   SEARCH | history loads received bits; lock after SYNC_LEN correct predictions
//   LOCKED | history free-runs on its own predictions; received bits are checked
module prbs32_checker
    import prbs_pkg::*;
#(
    parameter int SYNC_LEN    = 64,
    parameter int LOSS_THRESH = 8,
    parameter int WINDOW      = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int WB_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WE_W = $clog2(WINDOW + 1);
    localparam logic [WB_W-1:0] WB_LAST    = WB_W'(WINDOW - 1);
    localparam logic [WE_W-1:0] WE_THR     = WE_W'(LOSS_THRESH);
    localparam logic [7:0]      MATCH_LAST = 8'(SYNC_LEN - 1);

    prbs_state_e       state_q;
    logic [PRBS_W-1:0] hist_q;
    logic [5:0]        fill_q;
    logic [7:0]        match_q;
    logic [WB_W-1:0]   win_bits_q;
    logic [WE_W-1:0]   win_err_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic            pred;
    logic            mismatch;
    logic            wrap;
    logic [WE_W-1:0] win_err_d;
    logic            err_inc;
    logic            bit_inc;

    assign pred     = prbs_next(hist_q);
    assign mismatch = bit_in != pred;
    assign wrap     = win_bits_q == WB_LAST;

    // An error on the wrap bit belongs to the window that is just starting.
    always_comb begin
        win_err_d = wrap ? '0 : win_err_q;
        win_err_d = win_err_d + WE_W'(mismatch);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    SEARCH: begin
                        hist_q <= {hist_q[PRBS_W-2:0], bit_in};
                        if (fill_q != 6'd32) begin
                            fill_q <= fill_q + 6'd1;
                        end else if (!mismatch && (hist_q != '0)) begin
                            if (match_q == MATCH_LAST) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                match_q    <= '0;
                                win_bits_q <= '0;
                                win_err_q  <= '0;
                            end else begin
                                match_q <= match_q + 8'd1;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running local LFSR so a single channel error is seen only once.
                        hist_q      <= {hist_q[PRBS_W-2:0], pred};
                        err_pulse_q <= mismatch;
                        if (win_err_d == WE_THR) begin
                            state_q    <= SEARCH;
                            locked_q   <= 1'b0;
                            fill_q     <= '0;
                            match_q    <= '0;
                            win_bits_q <= '0;
                            win_err_q  <= '0;
                        end else begin
                            win_bits_q <= wrap ? '0 : win_bits_q + 1'b1;
                            win_err_q  <= win_err_d;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign bit_inc = bit_valid && (state_q == LOCKED);
    assign err_inc = bit_inc && mismatch;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_cnt),
        .inc_i (err_inc),
        .q_o   (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_cnt),
        .inc_i (bit_inc),
        .q_o   (bit_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule
